// File: rtl/sn74163.sv
// Pin-level SN74163 synchronous 4-bit binary counter: sync clear, sync load, count, ripple carry.
// Latency: Q updates one P2 rising edge after inputs; RCO is combinational from ENT and Q.
// Backpressure: none; ENP/ENT gate counting and all edges are ignored without valid power.
module sn74163 (
    input  logic P1,   // CLR_n
    input  logic P2,   // CLK
    input  logic P3,   // A (LSB)
    input  logic P4,   // B
    input  logic P5,   // C
    input  logic P6,   // D (MSB)
    input  logic P7,   // ENP
    input  logic P8,   // GND
    input  logic P9,   // LOAD_n
    input  logic P10,  // ENT
    output logic P11,  // QD
    output logic P12,  // QC
    output logic P13,  // QB
    output logic P14,  // QA
    output logic P15,  // RCO
    input  logic P16   // VCC
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic [3:0] load_dat;
    logic       power_ok;
    logic       count_en;

    assign power_ok = P16 & ~P8;
    assign load_dat = {P6, P5, P4, P3};
    assign count_en = P7 & P10;

    // Load and count only; clear is applied in the register so it wins over both.
    always_comb begin
        q_d = q_q;
        if (power_ok) begin
            if (!P9) begin
                q_d = load_dat;
            end else if (count_en) begin
                q_d = q_q + 4'd1;
            end
        end
    end

    // No power-on value: the count is undefined until the first clearing edge.
    always_ff @(posedge P2) begin
        if (!P1 && power_ok) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign {P11, P12, P13, P14} = q_q;
    assign P15 = P10 & (q_q == 4'hF);

endmodule

// File: tb/tb_sn74163.sv
// Randomized and directed bench for sn74163 against a pin-rule behavioural model.
module tb_sn74163;

    logic       clk = 1'b0;
    logic       clr_n, load_n, enp, ent, gnd, vcc;
    logic [3:0] d;
    logic       qd, qc, qb, qa, rco;
    logic [3:0] q;

    int checks = 0;
    int failures = 0;

    int   mq = 0;
    logic known = 1'b0;

    assign q = {qd, qc, qb, qa};

    sn74163 dut (
        .P1 (clr_n),
        .P2 (clk),
        .P3 (d[0]),
        .P4 (d[1]),
        .P5 (d[2]),
        .P6 (d[3]),
        .P7 (enp),
        .P8 (gnd),
        .P9 (load_n),
        .P10(ent),
        .P11(qd),
        .P12(qc),
        .P13(qb),
        .P14(qa),
        .P15(rco),
        .P16(vcc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the four priority rules applied to the pin values at each rising edge.
    always @(posedge clk) begin
        if (vcc === 1'b1 && gnd === 1'b0) begin
            if (clr_n === 1'b0) begin
                mq    = 0;
                known = 1'b1;
            end else if (load_n === 1'b0) begin
                mq = int'(d);
            end else if (enp === 1'b1 && ent === 1'b1) begin
                mq = (mq + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("model_q", q, 4'(mq));
            check("model_rco", {3'b000, rco}, {3'b000, (ent && mq == 15)});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [3:0] v);
        load_n = 1'b0;
        d      = v;
        step();
        load_n = 1'b1;
    endtask

    logic [15:0] visited;

    initial begin
        vcc = 1'b1; gnd = 1'b0;
        clr_n = 1'b0; load_n = 1'b1; enp = 1'b1; ent = 1'b1; d = 4'h0;
        #2;

        // Clear with counting enabled
        step();
        check("reset_q", q, 4'h0);
        check("reset_rco", {3'b000, rco}, 4'h0);
        clr_n = 1'b1;

        // Clear low between edges must not touch Q
        enp = 1'b0;
        load(4'h5);
        clr_n = 1'b0;
        #1;
        check("clr_no_edge", q, 4'h5);
        clr_n = 1'b1;

        // Load then count to 15 and wrap
        load(4'hA);
        check("load_a", q, 4'hA);
        enp = 1'b1; ent = 1'b1;
        repeat (5) step();
        check("count_to_f", q, 4'hF);
        check("rco_at_f", {3'b000, rco}, 4'h1);
        step();
        check("wrap_q", q, 4'h0);
        check("wrap_rco", {3'b000, rco}, 4'h0);

        // ENP low holds
        enp = 1'b0;
        load(4'h7);
        repeat (3) step();
        check("enp_hold", q, 4'h7);

        // Load 1111 with ENT high raises RCO; ENT gates RCO without a clock
        load(4'hF);
        check("load_f_rco", {3'b000, rco}, 4'h1);
        enp = 1'b1;
        ent = 1'b0;
        #1;
        check("ent_low_rco", {3'b000, rco}, 4'h0);
        step();
        check("ent_low_hold", q, 4'hF);
        enp = 1'b0;
        ent = 1'b1;
        #1;
        check("ent_high_rco", {3'b000, rco}, 4'h1);

        // Clear beats load and count; load ignores enables
        clr_n = 1'b0; load_n = 1'b0; d = 4'hC; enp = 1'b1; ent = 1'b1;
        step();
        check("clr_over_load", q, 4'h0);
        clr_n = 1'b1; enp = 1'b0;
        step();
        check("load_ignores_en", q, 4'hC);
        load_n = 1'b1;

        // No power: edges ignored
        load(4'h5);
        vcc = 1'b0; enp = 1'b1; ent = 1'b1;
        repeat (4) step();
        check("power_hold", q, 4'h5);
        vcc = 1'b1;
        step();
        check("power_resume", q, 4'h6);

        // Full cycle from zero
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        visited = 16'h0001;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("exh_q", q, 4'(i % 16));
            check("exh_rco", {3'b000, rco}, {3'b000, (i % 16 == 15)});
            visited[q] = 1'b1;
        end
        check("exh_vis_lo", visited[7:4], 4'hF);
        check("exh_vis_hi", visited[15:12], 4'hF);

        // Random pins, including mid-cycle enable/clear wiggles
        for (int n = 0; n < 3000; n++) begin
            clr_n  = ($urandom_range(0, 15) != 0);
            load_n = ($urandom_range(0, 7) != 0);
            enp    = ($urandom_range(0, 3) != 0);
            ent    = ($urandom_range(0, 3) != 0);
            vcc    = ($urandom_range(0, 15) != 0);
            gnd    = ($urandom_range(0, 31) == 0);
            d      = 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sn74163.md
SN74163 -- requirements
Module: sn74163

Interface
REQ-001 The block SHALL have no parameters; it is a pin-level model of the TTL SN74163 synchronous 4-bit binary counter.
REQ-002 P2  input  1  CLK; the single clock, with all state changes on its rising edge.
REQ-003 P1  input  1  CLR_n; reset, synchronous and active-low, sampled on the P2 rising edge.
REQ-004 P3  input  1  data A (LSB).
REQ-005 P4  input  1  data B.
REQ-006 P5  input  1  data C.
REQ-007 P6  input  1  data D (MSB).
REQ-008 P7  input  1  ENP; count enable P.
REQ-009 P8  input  1  GND; must be 0 for the device to operate.
REQ-010 P9  input  1  LOAD_n; synchronous parallel load, active-low.
REQ-011 P10  input  1  ENT; count enable T, which also gates carry out.
REQ-012 P11  output  1  QD (MSB of count).
REQ-013 P12  output  1  QC.
REQ-014 P13  output  1  QB.
REQ-015 P14  output  1  QA (LSB of count).
REQ-016 P15  output  1  RCO; ripple carry out.
REQ-017 P16  input  1  VCC; must be 1 for the device to operate.

Function
REQ-018 The count Q[3:0] SHALL map as {P11,P12,P13,P14}, and the load data D[3:0] SHALL map as {P6,P5,P4,P3}.
REQ-019 The power-valid condition SHALL be (P16==1 && P8==0); while it is false, P2 edges SHALL be ignored and all outputs SHALL hold.
REQ-020 On each P2 rising edge with power valid, the first matching rule below SHALL apply.
REQ-021 Rule 1: if P1==0, then Q <= 0000.
REQ-022 Rule 2: else if P9==0, then Q <= D; load ignores ENP and ENT.
REQ-023 Rule 3: else if P7==1 and P10==1, then Q <= Q+1 modulo 16, so 1111 wraps to 0000.
REQ-024 Rule 4: otherwise Q holds.
REQ-025 Register latency SHALL be one P2 edge; Q SHALL be updated only at P2 rising edges and SHALL never change asynchronously.
REQ-026 RCO SHALL be combinational: P15 = P10 AND (Q==1111); it follows P10 without waiting for a clock.
REQ-027 ENP SHALL NOT affect RCO.
REQ-028 Simultaneous CLR_n=0 and LOAD_n=0 SHALL resolve to clear, since clear has priority.
REQ-029 When P1 and P9 are both low together with counting enabled, the result SHALL still be clear.
REQ-030 Load with D=1111 and P10=1 SHALL assert RCO in the cycle after the edge.
REQ-031 Wrap-around SHALL be counting from 1111 with ENP=ENT=1: the result is Q=0000, and RCO falls after that edge.
REQ-032 Cascading: with this RCO driving the ENT of a next stage, the pair SHALL form a synchronous 8-bit counter with no extra logic.
REQ-033 Changes on P1, P3-P7, P9 or P10 between clock edges SHALL NOT alter Q.

Reset
REQ-034 A P2 rising edge with P1==0 and power valid SHALL give Q=0000, and P15=0 from that edge onward regardless of P10.
REQ-035 Reset SHALL be purely synchronous: P1 low with no P2 edge SHALL leave Q unchanged.
REQ-036 If reset is asserted mid-count, it SHALL take effect at the next edge and override any pending load or increment.
REQ-037 Before the first clearing edge, Q SHALL be unknown (X); the bench SHALL apply reset before checking any value.

Verification
REQ-038 Reset: P1=0 for 1 edge, P9=1, P7=P10=1 -> Q=0000, P15=0; P1=0 with no edge -> Q unchanged.
REQ-039 Load/count: D=1010, P9=0 for 1 edge -> Q=1010; then P9=1, ENP=ENT=1 for 5 edges -> Q=1111 and P15=1 -> next edge Q=0000, P15=0.
REQ-040 Enables: Q=0111 with P7=0, P10=1 for 3 edges -> Q=0111. Then P10=0 at Q=1111 -> Q holds and P15=0 immediately; P10 returns to 1 -> P15=1 with no clock edge.
REQ-041 Priority: P1=0, P9=0, D=1100, ENP=ENT=1 on one edge -> Q=0000. Then P1=1, P9=0, ENP=0 -> Q=1100, showing load ignores the enables.
REQ-042 Power: P16=0 with Q=0101 and 4 edges with counting enabled -> Q=0101 held. Restore P16=1 -> counting resumes at 0110.
REQ-043 Exhaustive: from 0000, 16 enabled edges -> every value 0..15 is visited once and Q returns to 0000; P15 is high only while Q=1111.
